// File: rtl/wb_master_standard_pkg.sv
// Shared types and helpers for the Wishbone classic single-transfer master.
package wb_master_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  // Wait counter must hold 0..timeout-1; a disabled timeout still needs one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_master_standard_if.sv
// Command/response stream plus Wishbone classic bus signals of the master.
interface wb_master_standard_if #(
  parameter int adr_width = 16,
  parameter int dat_width = 16
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_we;
  logic [adr_width-1:0] cmd_adr;
  logic [dat_width-1:0] cmd_dat;

  logic                 rsp_valid;
  logic [dat_width-1:0] rsp_dat;
  logic                 rsp_err;

  logic                 wb_cyc;
  logic                 wb_stb;
  logic                 wb_we;
  logic [adr_width-1:0] wb_adr;
  logic [dat_width-1:0] wb_dat_m;
  logic [dat_width-1:0] wb_dat_s;
  logic                 wb_ack;
  logic                 wb_err;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, wb_dat_s, wb_ack, wb_err,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_m
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, wb_dat_s, wb_ack, wb_err,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_m
  );

endinterface

// File: rtl/wb_master_standard.sv
// Wishbone classic master: one command in, one single read/write cycle out,
// one response back, with a bounded wait for ack.
module wb_master_standard
  import wb_master_pkg::*;
#(
  parameter int adr_width = 16,
  parameter int dat_width = 16,
  parameter int timeout   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_master_standard_if.master bus
);

  localparam int cnt_w = cnt_width(timeout);

  typedef struct packed {
    logic [dat_width-1:0] dat;
    logic                 err;
  } rsp_t;

  typedef struct packed {
    logic                 cyc;
    logic                 we;
    logic [adr_width-1:0] adr;
    logic [dat_width-1:0] dat;
  } req_t;

  state_t           state_q, state_d;
  req_t             req_q, req_d;
  rsp_t             rsp_q, rsp_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             timeout_hit;

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign timeout_hit   = (timeout != 0) && (cnt_q == cnt_w'(timeout - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUS;
      BUS:     if (bus.wb_ack || bus.wb_err || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    req_d       = req_q;
    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        req_d.cyc = 1'b0;
        if (accept) begin
          req_d = '{cyc: 1'b1, we: bus.cmd_we, adr: bus.cmd_adr, dat: bus.cmd_dat};
          cnt_d = '0;
        end
      end
      BUS: begin
        // ack outranks both err and an expiring timeout on the same edge
        if (bus.wb_ack) begin
          req_d.cyc   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_d       = '{dat: (req_q.we ? '0 : bus.wb_dat_s), err: 1'b0};
        end else if (bus.wb_err || timeout_hit) begin
          req_d.cyc   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_d       = '{dat: '0, err: 1'b1};
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      default: req_d.cyc = 1'b0;
    endcase
  end

  assign bus.wb_cyc    = req_q.cyc;
  assign bus.wb_stb    = req_q.cyc;
  assign bus.wb_we     = req_q.we;
  assign bus.wb_adr    = req_q.adr;
  assign bus.wb_dat_m  = req_q.dat;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_q.dat;
  assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_wb_master_standard.sv
// Randomized scoreboard bench for wb_master_standard against a memory-level
// reference model and a configurable behavioural Wishbone slave.
module tb_wb_master_standard;

  localparam int aw  = 16;
  localparam int dw  = 16;
  localparam int tmo = 15;

  typedef enum int {M_ACK, M_ERR, M_BOTH, M_NONE} mode_e;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [15:0] exp_dat;
    logic        exp_err;
    int          hs;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_master_standard_if #(.adr_width(aw), .dat_width(dw)) bus ();

  wb_master_standard #(.adr_width(aw), .dat_width(dw), .timeout(tmo)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          edge_cnt = 0;
  bit          mon_en   = 1'b0;
  exp_t        sb[$];
  logic [15:0] model_mem [logic [15:0]];
  logic [15:0] slave_mem [logic [15:0]];
  int          slave_wait = 0;
  mode_e       slave_mode = M_ACK;
  int          s_cnt      = 0;
  logic [15:0] last_dat   = '0;
  logic        last_err   = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  task automatic fail(input string name, input int val);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0d, required none (edge %0d)", name, val, edge_cnt);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] adr);
    return model_mem.exists(adr) ? model_mem[adr] : 16'h0;
  endfunction

  // Behavioural slave: ack (or err) after slave_wait wait states.
  always @(posedge clk) begin
    #1;
    bus.wb_ack   = 1'b0;
    bus.wb_err   = 1'b0;
    bus.wb_dat_s = 16'($urandom);
    if (bus.wb_cyc && bus.wb_stb) begin
      if (s_cnt == slave_wait) begin
        s_cnt = 0;
        if (slave_mode == M_ACK || slave_mode == M_BOTH) begin
          bus.wb_ack = 1'b1;
          if (bus.wb_we) slave_mem[bus.wb_adr] = bus.wb_dat_m;
          else bus.wb_dat_s = slave_mem.exists(bus.wb_adr) ? slave_mem[bus.wb_adr] : 16'h0;
        end
        if (slave_mode == M_ERR || slave_mode == M_BOTH) bus.wb_err = 1'b1;
      end else begin
        s_cnt++;
      end
    end else begin
      s_cnt = 0;
    end
  end

  // Issue one command; caller sits 1 time unit after a rising edge.
  task automatic issue(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                       input int w, input mode_e mode, output int hs);
    exp_t e;
    int   budget = 0;
    hs = -1;
    while (bus.cmd_ready !== 1'b1) begin
      if (budget >= 300) begin
        fail("cmd_ready_wait", budget);
        bus.cmd_valid = 1'b0;
        return;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_we    = 1'($urandom);
      bus.cmd_adr   = 16'($urandom);
      bus.cmd_dat   = 16'($urandom);
      tick(1);
      budget++;
    end
    slave_wait    = w;
    slave_mode    = mode;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    hs            = edge_cnt + 1;
    e.we  = we;
    e.adr = adr;
    e.dat = dat;
    e.hs  = hs;
    if (mode == M_ACK || mode == M_BOTH) begin
      e.exp_err = 1'b0;
      e.exp_dat = we ? 16'h0 : model_rd(adr);
      if (we) model_mem[adr] = dat;
      e.due = hs + 1 + w;
    end else begin
      e.exp_err = 1'b1;
      e.exp_dat = 16'h0;
      e.due = (mode == M_NONE) ? hs + tmo : hs + 1 + w;
    end
    sb.push_back(e);
    tick(1);
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'($urandom);
    bus.cmd_adr   = 16'($urandom);
    bus.cmd_dat   = 16'($urandom);
  endtask

  // Monitor: bus shape and responses against the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst) begin
      last_dat = '0;
      last_err = 1'b0;
    end else if (mon_en) begin
      bit exp_cyc;
      exp_cyc = (sb.size() > 0) && (edge_cnt >= sb[0].hs) && (edge_cnt < sb[0].due);
      check("wb_cyc", bus.wb_cyc, exp_cyc);
      check("wb_stb", bus.wb_stb, exp_cyc);
      check("cmd_ready", bus.cmd_ready, !exp_cyc);
      if (exp_cyc) begin
        check("wb_we", bus.wb_we, sb[0].we);
        check("wb_adr", bus.wb_adr, sb[0].adr);
        if (sb[0].we) check("wb_dat_m", bus.wb_dat_m, sb[0].dat);
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          fail("unexpected_rsp", edge_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_dat", bus.rsp_dat, e.exp_dat);
          check("rsp_err", bus.rsp_err, e.exp_err);
          check("rsp_edge", edge_cnt, e.due);
          last_dat = e.exp_dat;
          last_err = e.exp_err;
        end
      end else begin
        check("rsp_dat_hold", bus.rsp_dat, last_dat);
        check("rsp_err_hold", bus.rsp_err, last_err);
      end
    end
  end

  initial begin
    int hs, prev;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;

    tick(2);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_dat", bus.rsp_dat, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_cyc", bus.wb_cyc, 0);
    check("rst_stb", bus.wb_stb, 0);
    check("rst_we", bus.wb_we, 0);
    check("rst_adr", bus.wb_adr, 0);
    check("rst_dat_m", bus.wb_dat_m, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick(1);
    check("ready_after_rst", bus.cmd_ready, 1);

    // zero-wait writes with an idle cycle after each, then back-to-back reads
    for (int i = 1; i <= 10; i++) begin
      issue(1'b1, 16'(i), 16'(100 + i), 0, M_ACK, hs);
      tick(2);
    end
    prev = -1;
    for (int i = 1; i <= 10; i++) begin
      issue(1'b0, 16'(i), 16'h0, 0, M_ACK, hs);
      if (prev >= 0) check("spacing_w0", hs - prev, 2);
      prev = hs;
    end

    // three wait states, back-to-back
    prev = -1;
    for (int i = 11; i <= 20; i++) begin
      issue(1'b1, 16'(i), 16'(200 + i), 3, M_ACK, hs);
      if (prev >= 0) check("spacing_w3", hs - prev, 5);
      prev = hs;
    end
    prev = -1;
    for (int i = 11; i <= 20; i++) begin
      issue(1'b0, 16'(i), 16'h0, 3, M_ACK, hs);
      if (prev >= 0) check("spacing_w3_rd", hs - prev, 5);
      prev = hs;
    end

    // timeout, then ack landing exactly on the timeout edge
    issue(1'b0, 16'h0055, 16'h0, 0, M_NONE, hs);
    issue(1'b0, 16'h0001, 16'h0, tmo - 1, M_ACK, hs);

    // bus error on a write, then ack+err together
    issue(1'b1, 16'h0007, 16'h1234, 2, M_ERR, hs);
    issue(1'b0, 16'h0007, 16'h0, 0, M_ACK, hs);
    issue(1'b1, 16'h0008, 16'h5678, 1, M_BOTH, hs);
    issue(1'b0, 16'h0008, 16'h0, 1, M_BOTH, hs);

    // reset in the second cycle of a three-wait read
    issue(1'b0, 16'h0003, 16'h0, 3, M_ACK, hs);
    tick(1);
    rst = 1'b1;
    sb.delete();
    tick(1);
    check("rst_mid_cyc", bus.wb_cyc, 0);
    check("rst_mid_stb", bus.wb_stb, 0);
    check("rst_mid_rsp", bus.rsp_valid, 0);
    check("rst_mid_ready", bus.cmd_ready, 0);
    rst = 1'b0;
    tick(1);
    check("rst_mid_ready_after", bus.cmd_ready, 1);
    check("rst_mid_rsp_after", bus.rsp_valid, 0);
    issue(1'b1, 16'h0002, 16'hBEEF, 0, M_ACK, hs);
    issue(1'b0, 16'h0002, 16'h0, 0, M_ACK, hs);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      int    r;
      mode_e m;
      r = int'($urandom_range(0, 11));
      m = (r == 0) ? M_ERR : (r == 1) ? M_BOTH : (r == 2) ? M_NONE : M_ACK;
      issue(1'($urandom), 16'($urandom_range(0, 31)), 16'($urandom),
            int'($urandom_range(0, 4)), m, hs);
      tick(int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    check("sb_drained", sb.size(), 0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
